// File: rtl/hilo_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Stalls the pipeline while iterating and returns {remainder, quotient} for HI/LO.
module hilo_div #(
   parameter int unsigned WIDTH        = 32,
   parameter logic [4:0]  DIV_CONTROL  = 5'b11010,
   parameter logic [4:0]  DIVU_CONTROL = 5'b11011
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [4:0]         alucontrol,
   input  logic               start,
   input  logic               flush,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               div_stall,
   output logic               ready,
   output logic [2*WIDTH-1:0] result
);

   localparam int unsigned   CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state_q,    state_d;
   logic [CW-1:0]      cnt_q,      cnt_d;
   logic               signed_q,   signed_d;
   logic               qsign_q,    qsign_d;
   logic               rsign_q,    rsign_d;
   logic               dz_q,       dz_d;
   logic [WIDTH-1:0]   divisor_q,  divisor_d;
   logic [WIDTH-1:0]   rem_q,      rem_d;
   logic [WIDTH-1:0]   quo_q,      quo_d;
   logic [WIDTH-1:0]   dividend_q, dividend_d;
   logic [2*WIDTH-1:0] result_q,   result_d;

   logic               is_div;
   logic               is_signed;
   logic               accept;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH:0]     r_shift;
   logic [WIDTH:0]     r_diff;
   logic               r_fits;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [2*WIDTH-1:0] final_result;

   // Operand decode and magnitude conversion for the accept cycle.
   always_comb begin
      is_div    = (alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL);
      is_signed = (alucontrol == DIV_CONTROL);
      accept    = (state_q == S_IDLE) && start && is_div && !flush;
      a_neg     = is_signed && a[WIDTH-1];
      b_neg     = is_signed && b[WIDTH-1];
      a_abs     = a_neg ? (~a + 1'b1) : a;
      b_abs     = b_neg ? (~b + 1'b1) : b;
   end

   // The shifted remainder needs one extra bit so the compare never overflows.
   always_comb begin
      r_shift = {rem_q, quo_q[WIDTH-1]};
      r_diff  = r_shift - {1'b0, divisor_q};
      r_fits  = (r_shift >= {1'b0, divisor_q});
   end

   // Divide-by-zero overrides the iteration result with {dividend, all ones}.
   always_comb begin
      quo_fix      = (signed_q && qsign_q) ? (~quo_q + 1'b1) : quo_q;
      rem_fix      = (signed_q && rsign_q) ? (~rem_q + 1'b1) : rem_q;
      final_result = dz_q ? {dividend_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      signed_d   = signed_q;
      qsign_d    = qsign_q;
      rsign_d    = rsign_q;
      dz_d       = dz_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dividend_d = dividend_q;
      result_d   = result_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d    = S_BUSY;
               cnt_d      = '0;
               signed_d   = is_signed;
               qsign_d    = a_neg ^ b_neg;
               rsign_d    = a_neg;
               dz_d       = (b == '0);
               divisor_d  = b_abs;
               rem_d      = '0;
               quo_d      = a_abs;
               dividend_d = a;
            end
         end
         S_BUSY: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               rem_d = r_fits ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], r_fits};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_STEP) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!flush) begin
               result_d = final_result;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         signed_q   <= 1'b0;
         qsign_q    <= 1'b0;
         rsign_q    <= 1'b0;
         dz_q       <= 1'b0;
         divisor_q  <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dividend_q <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         signed_q   <= signed_d;
         qsign_q    <= qsign_d;
         rsign_q    <= rsign_d;
         dz_q       <= dz_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dividend_q <= dividend_d;
         result_q   <= result_d;
      end
   end

   // Result is presented during DONE itself so HI/LO can be written while the pipe advances.
   always_comb begin
      ready     = (state_q == S_DONE) && !flush;
      result    = ready ? final_result : result_q;
      div_stall = accept || (state_q == S_BUSY);
   end

endmodule

// File: tb/tb_hilo_div.sv
// Directed testbench for hilo_div: signed/unsigned divides, divide-by-zero,
// flush cancellation, non-divide pass-through and asynchronous reset.
module tb_hilo_div;

   localparam int unsigned WIDTH        = 32;
   localparam logic [4:0]  DIV_CONTROL  = 5'b11010;
   localparam logic [4:0]  DIVU_CONTROL = 5'b11011;
   localparam logic [4:0]  ADD_CONTROL  = 5'b00010;

   logic               clk = 1'b0;
   logic               resetn;
   logic [4:0]         alucontrol;
   logic               start;
   logic               flush;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               div_stall;
   logic               ready;
   logic [2*WIDTH-1:0] result;

   int nChecks = 0;
   int nErrors = 0;

   hilo_div #(
      .WIDTH        (WIDTH),
      .DIV_CONTROL  (DIV_CONTROL),
      .DIVU_CONTROL (DIVU_CONTROL)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .alucontrol (alucontrol),
      .start      (start),
      .flush      (flush),
      .a          (a),
      .b          (b),
      .div_stall  (div_stall),
      .ready      (ready),
      .result     (result)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] ctrl, input logic st, input logic fl,
                                input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      alucontrol = ctrl;
      start      = st;
      flush      = fl;
      a          = av;
      b          = bv;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Issues one divide, scrambles the upstream operands after accept, and checks latency/result.
   task automatic runDiv(input string tag, input logic [4:0] ctrl, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic [63:0] expected);
      int cycles;
      int stallCycles;
      applyStimulus(ctrl, 1'b1, 1'b0, av, bv);
      #1;
      checkOutput({tag, " stall@accept"}, 64'(div_stall), 64'(1));
      stallCycles = div_stall ? 1 : 0;
      tick();
      applyStimulus(ADD_CONTROL, 1'b0, 1'b0, ~av, bv + 32'd5);
      cycles = 1;
      while (!ready && cycles <= 40) begin
         if (div_stall) stallCycles++;
         tick();
         cycles++;
      end
      checkOutput({tag, " latency"}, 64'(cycles), 64'(33));
      checkOutput({tag, " stall_cycles"}, 64'(stallCycles), 64'(33));
      checkOutput({tag, " result"}, result, expected);
      checkOutput({tag, " stall@done"}, 64'(div_stall), 64'(0));
      tick();
      checkOutput({tag, " ready_after"}, 64'(ready), 64'(0));
      checkOutput({tag, " result_hold"}, result, expected);
   endtask

   initial begin
      int readyPulses;

      resetn = 1'b0;
      applyStimulus(5'd0, 1'b0, 1'b0, '0, '0);
      #1;
      checkOutput("reset ready", 64'(ready), 64'(0));
      checkOutput("reset stall", 64'(div_stall), 64'(0));
      checkOutput("reset result", result, 64'(0));
      repeat (2) tick();
      resetn = 1'b1;
      tick();

      runDiv("divu 7/2", DIVU_CONTROL, 32'd7, 32'd2, {32'h1, 32'h3});
      runDiv("div -7/2", DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      runDiv("div 7/-2", DIV_CONTROL, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD});
      runDiv("div min/-1", DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
      runDiv("divu max/1", DIVU_CONTROL, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF});
      runDiv("div -5/0", DIV_CONTROL, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
      runDiv("divu 0x1234/0", DIVU_CONTROL, 32'h1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF});

      // Flush in the tenth BUSY cycle must cancel without touching result.
      applyStimulus(DIV_CONTROL, 1'b1, 1'b0, 32'd100, 32'd7);
      tick();
      applyStimulus(DIV_CONTROL, 1'b0, 1'b0, 32'd100, 32'd7);
      repeat (9) tick();
      flush = 1'b1;
      #1;
      checkOutput("flush busy stall", 64'(div_stall), 64'(1));
      tick();
      flush = 1'b0;
      #1;
      checkOutput("flush idle stall", 64'(div_stall), 64'(0));
      readyPulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready) readyPulses++;
         tick();
      end
      checkOutput("flush no ready", 64'(readyPulses), 64'(0));
      checkOutput("flush result kept", result, {32'h0000_1234, 32'hFFFF_FFFF});

      runDiv("divu 100/7", DIVU_CONTROL, 32'd100, 32'd7, {32'h2, 32'hE});

      // Non-divide control codes pass through without stalling.
      applyStimulus(ADD_CONTROL, 1'b1, 1'b0, 32'd9, 32'd3);
      #1;
      checkOutput("add stall", 64'(div_stall), 64'(0));
      tick();
      start = 1'b0;
      #1;
      checkOutput("add stays idle", 64'(div_stall), 64'(0));
      checkOutput("add no ready", 64'(ready), 64'(0));

      // Accept condition together with flush is refused.
      applyStimulus(DIVU_CONTROL, 1'b1, 1'b1, 32'd9, 32'd3);
      #1;
      checkOutput("flush+accept stall", 64'(div_stall), 64'(0));
      tick();
      applyStimulus(DIVU_CONTROL, 1'b0, 1'b0, 32'd9, 32'd3);
      #1;
      checkOutput("flush+accept idle", 64'(div_stall), 64'(0));

      // Asynchronous reset in the middle of BUSY.
      applyStimulus(DIVU_CONTROL, 1'b1, 1'b0, 32'd100, 32'd7);
      tick();
      start = 1'b0;
      repeat (5) tick();
      checkOutput("busy before reset", 64'(div_stall), 64'(1));
      resetn = 1'b0;
      #1;
      checkOutput("async reset stall", 64'(div_stall), 64'(0));
      checkOutput("async reset ready", 64'(ready), 64'(0));
      checkOutput("async reset result", result, 64'(0));
      tick();
      resetn = 1'b1;
      readyPulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready || div_stall) readyPulses++;
         tick();
      end
      checkOutput("post reset quiet", 64'(readyPulses), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
